// File: rtl/constants_pkg.sv
// rtl/constants_pkg.sv - shared processor-environment enums
package constants_pkg;

  typedef enum logic [2:0] {
    FETCH_START,
    FETCH_END,
    DECODE,
    EXECUTE,
    MEMORY_ACCESS,
    WRITE_BACK
  } ExecutionStage;

  typedef enum logic {
    TRACE_WRAP      = 1'b0,
    TRACE_STOP_FULL = 1'b1
  } TraceMode;

  typedef enum logic [1:0] {
    REC_IDLE,
    REC_CAPTURE,
    REC_POST,
    REC_FROZEN
  } RecorderState;

endpackage

// File: rtl/execution_trace_recorder_pkg.sv
// rtl/execution_trace_recorder_pkg.sv - trace recorder widths and helpers
package execution_trace_recorder_pkg;

  localparam int DROP_W = 8;

  function automatic int entry_width(input int stamp_w, input int pc_w,
                                     input int num_regs, input int data_w);
    return stamp_w + pc_w + num_regs * data_w;
  endfunction

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/execution_trace_recorder_if.sv
// rtl/execution_trace_recorder_if.sv - trace readout valid/ready port
interface execution_trace_recorder_if #(
  parameter int ENTRY_W = 88
);
  logic               rd_valid;
  logic               rd_ready;
  logic [ENTRY_W-1:0] rd_data;

  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/execution_trace_recorder_ring.sv
// rtl/execution_trace_recorder_ring.sv - trace_ring_buffer: circular entry store
// with optional overwrite-oldest on full and simultaneous push/pop.
module trace_ring_buffer #(
  parameter int WIDTH = 88,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     overwrite,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_pop;
  logic             do_push;
  logic             evict;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop || overwrite);
  // Overwrite drops the oldest entry: read pointer advances, count holds.
  assign evict   = push && full && !do_pop && overwrite;
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop || evict) rptr <= rptr + 1'b1;
      case ({do_push && !evict, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/execution_trace_recorder.sv
// rtl/execution_trace_recorder.sv - execution trace recorder top: FSM, trigger,
// stamp and drop counters. Optional per-capture log under TRACE_DISPLAY_EN.
module execution_trace_recorder
  import constants_pkg::*;
  import execution_trace_recorder_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int NUM_REGS     = 8,
  parameter int PC_W         = 8,
  parameter int DEPTH        = 16,
  parameter int STAMP_W      = 16,
  parameter int POST_TRIGGER = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  ExecutionStage              state,
  input  logic [PC_W-1:0]            pc,
  input  logic [NUM_REGS*DATA_W-1:0] regs,
  input  logic                       arm,
  input  TraceMode                   mode,
  input  logic                       trig_en,
  input  logic [PC_W-1:0]            trig_pc,
  execution_trace_recorder_if.master rd,
  output logic [$clog2(DEPTH):0]     count,
  output logic [DROP_W-1:0]          dropped,
  output RecorderState               rec_state,
  output logic                       triggered
);
  localparam int ENTRY_W = entry_width(STAMP_W, PC_W, NUM_REGS, DATA_W);
  localparam int PW      = $clog2(DEPTH);
  localparam logic [PW-1:0] POST_INIT = PW'(POST_TRIGGER);

  RecorderState        next_state;
  TraceMode            mode_q;
  logic [STAMP_W-1:0]  stamp;
  logic [PW-1:0]       post_cnt;
  logic [PW-1:0]       next_post;
  logic                next_trig;
  logic                capture;
  logic                trig_hit;
  logic                pop_ok;
  logic                full;
  logic                empty;
  logic                drop_event;
  logic [ENTRY_W-1:0]  entry;

  // arm wins over a same-cycle capture, which is simply discarded.
  assign capture    = (state == FETCH_END) && !arm &&
                      (rec_state == REC_CAPTURE || rec_state == REC_POST);
  assign trig_hit   = capture && (rec_state == REC_CAPTURE) && trig_en && (pc == trig_pc);
  assign pop_ok     = rd.rd_valid && rd.rd_ready;
  assign drop_event = capture && full && !pop_ok;
  assign entry      = {stamp, pc, regs};
  assign rd.rd_valid = !empty;

  trace_ring_buffer #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (arm),
    .push      (capture),
    .pop       (rd.rd_ready),
    .overwrite (mode_q == TRACE_WRAP),
    .wdata     (entry),
    .rdata     (rd.rd_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    next_state = rec_state;
    next_post  = post_cnt;
    next_trig  = triggered;
    if (arm) begin
      next_state = REC_CAPTURE;
      next_post  = '0;
      next_trig  = 1'b0;
    end else begin
      case (rec_state)
        REC_CAPTURE: begin
          if (trig_hit) begin
            next_trig  = 1'b1;
            next_post  = POST_INIT;
            next_state = (POST_TRIGGER == 0) ? REC_FROZEN : REC_POST;
          end
        end
        REC_POST: begin
          if (capture) begin
            next_post = post_cnt - 1'b1;
            if (post_cnt == PW'(1)) next_state = REC_FROZEN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rec_state <= REC_IDLE;
      post_cnt  <= '0;
      triggered <= 1'b0;
      mode_q    <= TRACE_WRAP;
      stamp     <= '0;
      dropped   <= '0;
    end else begin
      rec_state <= next_state;
      post_cnt  <= next_post;
      triggered <= next_trig;
      stamp     <= stamp + 1'b1;
      if (arm) begin
        mode_q  <= mode;
        dropped <= '0;
      end else if (drop_event) begin
        dropped <= sat_inc(dropped);
      end
    end
  end

`ifdef TRACE_DISPLAY_EN
  always @(posedge clk) begin
    if (reset_n && capture) begin
      if (drop_event && mode_q == TRACE_WRAP)
        $display("TRACE stamp=%h pc=%h regs=%h WRAP", stamp, pc, regs);
      else if (drop_event)
        $display("TRACE stamp=%h pc=%h regs=%h DROP", stamp, pc, regs);
      else
        $display("TRACE stamp=%h pc=%h regs=%h", stamp, pc, regs);
    end
  end
`endif

endmodule

// File: tb/tb_execution_trace_recorder.sv
// tb/tb_execution_trace_recorder.sv - bench for execution_trace_recorder
module tb_execution_trace_recorder;
  import constants_pkg::*;

  localparam int DEPTH = 16;
  localparam int EW    = 16 + 8 + 64;

  typedef struct {
    logic [15:0] stamp;
    logic [7:0]  pc;
    logic [63:0] regs;
  } entry_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  ExecutionStage state = FETCH_START;
  logic [7:0]    pc = '0;
  logic [63:0]   regs = '0;
  logic          arm = 1'b0;
  TraceMode      mode = TRACE_WRAP;
  logic          trig_en = 1'b0;
  logic [7:0]    trig_pc = '0;
  logic [4:0]    count;
  logic [7:0]    dropped;
  RecorderState  rec_state;
  logic          triggered;

  execution_trace_recorder_if #(.ENTRY_W(EW)) rd_if ();

  execution_trace_recorder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .state     (state),
    .pc        (pc),
    .regs      (regs),
    .arm       (arm),
    .mode      (mode),
    .trig_en   (trig_en),
    .trig_pc   (trig_pc),
    .rd        (rd_if),
    .count     (count),
    .dropped   (dropped),
    .rec_state (rec_state),
    .triggered (triggered)
  );

  always #5 clk = ~clk;

  logic [15:0] cyc;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= '0;
    else          cyc <= cyc + 16'd1;
  end

  entry_t       q[$];
  entry_t       m_last_pop;
  entry_t       last_entry;
  entry_t       caps[20];
  int           m_drop;
  bit           m_trig;
  int           m_post;
  RecorderState m_state;
  TraceMode     m_mode;
  logic [EW-1:0] pre_data;
  int           checks = 0;
  int           failures = 0;

  function automatic logic [EW-1:0] pack(input entry_t e);
    return {e.stamp, e.pc, e.regs};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_drop = 0; m_trig = 0; m_post = 0;
    m_state = REC_IDLE; m_mode = TRACE_WRAP;
  endtask

  task automatic model_update(input bit fe, input logic [7:0] p, input logic [63:0] r,
                              input bit ready, input bit a, input TraceMode md,
                              input logic [15:0] st);
    entry_t e;
    bit full, popped, cap;
    if (a) begin
      q.delete(); m_drop = 0; m_trig = 0; m_post = 0;
      m_mode = md; m_state = REC_CAPTURE;
      return;
    end
    full   = (q.size() == DEPTH);
    popped = ready && (q.size() > 0);
    cap    = fe && (m_state == REC_CAPTURE || m_state == REC_POST);
    if (popped) m_last_pop = q.pop_front();
    if (cap) begin
      e = '{st, p, r};
      last_entry = e;
      if (full && !popped) begin
        m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        if (m_mode == TRACE_WRAP) begin
          void'(q.pop_front());
          q.push_back(e);
        end
      end else begin
        q.push_back(e);
      end
      if (m_state == REC_CAPTURE && trig_en && p == trig_pc) begin
        m_trig = 1; m_post = 4;
        m_state = (m_post == 0) ? REC_FROZEN : REC_POST;
      end else if (m_state == REC_POST) begin
        m_post--;
        if (m_post == 0) m_state = REC_FROZEN;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_count"}, count, q.size());
    chk({tag, "_valid"}, rd_if.rd_valid, q.size() != 0);
    chk({tag, "_data"}, rd_if.rd_data, (q.size() != 0) ? pack(q[0]) : '0);
    chk({tag, "_dropped"}, dropped, m_drop);
    chk({tag, "_trig"}, triggered, m_trig);
    chk({tag, "_state"}, rec_state, m_state);
  endtask

  task automatic step(input bit fe, input logic [7:0] p, input bit ready,
                      input bit a, input TraceMode md);
    @(negedge clk);
    state = fe ? FETCH_END : EXECUTE;
    pc = p;
    regs = {$urandom, $urandom};
    rd_if.rd_ready = ready;
    arm = a;
    mode = md;
    #1;
    pre_data = rd_if.rd_data;
    model_update(fe, p, regs, ready, a, md, cyc);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rand_pc();
    logic [7:0] v;
    v = 8'($urandom_range(32, 255));
    return v;
  endfunction

  initial begin
    logic [15:0] first_stamp;
    logic [15:0] prev_stamp;
    logic [7:0]  tpcs[8];
    rd_if.rd_ready = 1'b0;
    model_reset();
    #2 reset_n = 1'b0;
    #2;
    check_model("reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    step(1, rand_pc(), 0, 0, TRACE_WRAP);
    step(1, rand_pc(), 0, 0, TRACE_WRAP);
    check_model("idle_ignore");

    step(0, 8'h00, 0, 1, TRACE_STOP_FULL);
    check_model("arm_stop");
    for (int i = 0; i < 20; i++) begin
      step(1, rand_pc(), 0, 0, TRACE_STOP_FULL);
      if (i == 0) first_stamp = last_entry.stamp;
      check_model("stop_cap");
    end
    chk("stop_count16", count, 16);
    chk("stop_dropped4", dropped, 4);
    chk("stop_first_stamp", rd_if.rd_data[EW-1 -: 16], first_stamp);

    step(1, rand_pc(), 1, 0, TRACE_STOP_FULL);
    chk("fullpop_oldest", pre_data, pack(m_last_pop));
    chk("fullpop_oldest_stamp", pre_data[EW-1 -: 16], first_stamp);
    chk("fullpop_count", count, 16);
    chk("fullpop_dropped", dropped, 4);
    check_model("fullpop");
    for (int i = 0; i < 17; i++) begin
      step(0, rand_pc(), 1, 0, TRACE_STOP_FULL);
      check_model("stop_drain");
    end

    step(0, 8'h00, 0, 1, TRACE_WRAP);
    for (int i = 0; i < 20; i++) begin
      step(1, rand_pc(), 0, 0, TRACE_WRAP);
      caps[i] = last_entry;
    end
    check_model("wrap_full");
    chk("wrap_count16", count, 16);
    chk("wrap_dropped4", dropped, 4);
    prev_stamp = '0;
    for (int i = 0; i < 16; i++) begin
      chk("wrap_drain_entry", rd_if.rd_data, pack(caps[i + 4]));
      if (i > 0) chk("wrap_stamp_incr", rd_if.rd_data[EW-1 -: 16] > prev_stamp, 1);
      prev_stamp = rd_if.rd_data[EW-1 -: 16];
      step(0, rand_pc(), 1, 0, TRACE_WRAP);
    end
    check_model("wrap_empty");

    trig_en = 1'b1;
    trig_pc = 8'h10;
    tpcs = '{8'h0C, 8'h0E, 8'h10, 8'h12, 8'h14, 8'h16, 8'h18, 8'h1A};
    step(0, 8'h00, 0, 1, TRACE_WRAP);
    for (int i = 0; i < 8; i++) begin
      step(1, tpcs[i], 0, 0, TRACE_WRAP);
      check_model("trig_cap");
      if (i == 6) chk("trig_frozen_after_18", rec_state, REC_FROZEN);
    end
    chk("trig_count7", count, 7);
    chk("trig_fired", triggered, 1);
    for (int i = 0; i < 7; i++) begin
      chk("trig_drain_pc", rd_if.rd_data[63 + 8 -: 8], tpcs[i]);
      step(0, 8'h00, 1, 0, TRACE_WRAP);
    end
    chk("trig_1A_not_stored", count, 0);
    trig_en = 1'b0;

    step(0, 8'h00, 0, 1, TRACE_WRAP);
    for (int i = 0; i < 3; i++) step(1, rand_pc(), 0, 0, TRACE_WRAP);
    step(1, rand_pc(), 0, 1, TRACE_WRAP);
    chk("armcap_count0", count, 0);
    chk("armcap_dropped0", dropped, 0);
    chk("armcap_state", rec_state, REC_CAPTURE);
    check_model("armcap");
    step(1, rand_pc(), 0, 0, TRACE_WRAP);
    step(1, rand_pc(), 0, 0, TRACE_WRAP);
    check_model("precut");
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_state", rec_state, REC_IDLE);
    chk("async_rst_valid", rd_if.rd_valid, 0);
    check_model("async_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
